// File: rtl/uart_pkg.sv
// Shared UART definitions (receiver now, transmitter later).
//   state_t    : frame state machine encoding
//   OVERSAMPLE : s_tick pulses per bit period
//   MID_TICK   : tick count from start edge to start-bit centre
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-FIFO word interface.
//   rx_done_tick : one-clk pulse, new word on dout (FIFO wr)
//   dout         : received word (FIFO w_data)
//   frame_err    : stop bit of last frame sampled low
//   par_err      : parity mismatch on last frame (0 when parity disabled)
// Modports: master = uart_rx (driver), slave = FIFO (sink).
interface uart_rx_if #(
   parameter int DBIT = 8
);
   logic            rx_done_tick;
   logic [DBIT-1:0] dout;
   logic            frame_err;
   logic            par_err;

   modport master (output rx_done_tick, output dout, output frame_err, output par_err);
   modport slave  (input  rx_done_tick, input  dout, input  frame_err, input  par_err);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output (two clk latency)
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one word per frame.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   rx     : raw serial line (idle high, asynchronous)
//   s_tick : 16x baud enable pulse
//   rx_if  : master side of uart_rx_if (rx_done_tick, dout, frame_err, par_err)
// Parameters: DBIT data bits (5..9), SB_TICK stop ticks (16/24/32).
// Build option: define UART_RX_PARITY_EN to add an even-parity bit after DATA.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      rx,
   input  logic      s_tick,
   uart_rx_if.master rx_if
);
   // s must hold SB_TICK-1 when stop bits span more than one bit period
   localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [S_W-1:0] S_MID  = S_W'(MID_TICK);
   localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
   localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

   logic            rx_s;
   state_t          state;
   logic [S_W-1:0]  s;
   logic [N_W-1:0]  n;
   logic [DBIT-1:0] b;
   logic            done_q;
   logic [DBIT-1:0] dout_q;
   logic            ferr_q;
`ifdef UART_RX_PARITY_EN
   localparam logic ODD = 1'b0;
   logic            parity_bit;
   logic            perr_q;
`endif

   sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         s      <= '0;
         n      <= '0;
         b      <= '0;
         done_q <= 1'b0;
         dout_q <= '0;
         ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s == S_MID) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s == S_BIT) begin
                     s <= '0;
                     b <= {rx_s, b[DBIT-1:1]};
                     if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s == S_BIT) begin
                     s          <= '0;
                     parity_bit <= rx_s;
                     state      <= STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (s == S_STOP) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                     dout_q <= b;
                     ferr_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                     perr_q <= (^b) ^ parity_bit ^ ODD;
`endif
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx_if.rx_done_tick = done_q;
   assign rx_if.dout         = dout_q;
   assign rx_if.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.par_err      = perr_q;
`else
   assign rx_if.par_err      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at 64 clk per bit (s_tick every 4 clk).
module tb_uart_rx;
   logic clk;
   logic reset;
   logic rx;
   logic s_tick;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned done_cnt = 0;
   int unsigned run      = 0;
   int unsigned max_run  = 0;
   int unsigned tick_div = 0;

   uart_rx_if #(.DBIT(8)) rif ();

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .rx     (rx),
      .s_tick (s_tick),
      .rx_if  (rif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // baud tick: one clk high every 4 clk, changed on the inactive edge
   initial begin
      s_tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_div = (tick_div + 1) % 4;
         s_tick   = (tick_div == 0);
      end
   end

   // pulse counter and pulse-width tracker
   initial begin
      forever begin
         @(negedge clk);
         if (rif.rx_done_tick === 1'b1) begin
            run = run + 1;
            if (run == 1) done_cnt = done_cnt + 1;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int unsigned cnt);
      repeat (cnt) @(negedge clk);
   endtask

   // stop_low: clk cycles the stop bit is held low before returning high
   task automatic send_frame(input logic [7:0] data, input int unsigned stop_low,
                             input bit with_par, input logic par_bit);
      rx = 1'b0;
      wait_clk(64);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         wait_clk(64);
      end
      if (with_par) begin
         rx = par_bit;
         wait_clk(64);
      end
      if (stop_low > 0) begin
         rx = 1'b0;
         wait_clk(stop_low);
      end
      rx = 1'b1;
      wait_clk(64 - stop_low);
   endtask

   initial begin
      bit wp;
`ifdef UART_RX_PARITY_EN
      wp = 1'b1;
`else
      wp = 1'b0;
`endif
      reset = 1'b0;
      rx    = 1'b1;
      wait_clk(5);
      check("reset_done",  32'(rif.rx_done_tick), 32'h0);
      check("reset_dout",  32'(rif.dout),         32'h0);
      check("reset_ferr",  32'(rif.frame_err),    32'h0);
      check("reset_perr",  32'(rif.par_err),      32'h0);
      check("reset_sync",  32'(dut.rx_s),         32'h1);
      reset = 1'b1;
      wait_clk(20);

      // basic frame
      send_frame(8'h55, 0, wp, 1'b1);
      check("f55_cnt",   done_cnt,            32'd1);
      check("f55_dout",  32'(rif.dout),       32'h55);
      check("f55_ferr",  32'(rif.frame_err),  32'h0);
      check("f55_width", max_run,             32'd1);

      // short low glitch while idle
      rx = 1'b0;
      wait_clk(12);
      rx = 1'b1;
      wait_clk(200);
      check("glitch_cnt",  done_cnt,          32'd1);
      check("glitch_dout", 32'(rif.dout),     32'h55);

      // back-to-back frames
      send_frame(8'hA3, 0, wp, 1'b0);
      check("bb1_cnt",  done_cnt,             32'd2);
      check("bb1_dout", 32'(rif.dout),        32'hA3);
      send_frame(8'h0F, 0, wp, 1'b0);
      check("bb2_cnt",  done_cnt,             32'd3);
      check("bb2_dout", 32'(rif.dout),        32'h0F);

      // stop bit low over its centre, then line returns high
      send_frame(8'hFF, 48, wp, 1'b0);
      check("ferr_cnt",  done_cnt,            32'd4);
      check("ferr_dout", 32'(rif.dout),       32'hFF);
      check("ferr_flag", 32'(rif.frame_err),  32'h1);
      wait_clk(200);
      check("ferr_nospur", done_cnt,          32'd4);
      send_frame(8'h5A, 0, wp, 1'b0);
      check("clr_cnt",  done_cnt,             32'd5);
      check("clr_dout", 32'(rif.dout),        32'h5A);
      check("clr_ferr", 32'(rif.frame_err),   32'h0);

      // reset in the middle of data bit 4 of 0x3C
      rx = 1'b0;
      wait_clk(64);
      for (int i = 0; i < 4; i++) begin
         rx = (8'h3C >> i) & 8'h01;
         wait_clk(64);
      end
      rx = 1'b1;
      wait_clk(32);
      reset = 1'b0;
      #1;
      check("mrst_done", 32'(rif.rx_done_tick), 32'h0);
      check("mrst_dout", 32'(rif.dout),         32'h0);
      check("mrst_ferr", 32'(rif.frame_err),    32'h0);
      check("mrst_perr", 32'(rif.par_err),      32'h0);
      check("mrst_sync", 32'(dut.rx_s),         32'h1);
      wait_clk(10);
      rx    = 1'b1;
      reset = 1'b1;
      wait_clk(100);
      check("mrst_nospur", done_cnt, 32'd5);
      send_frame(8'h3C, 0, wp, 1'b0);
      check("f3c_cnt",  done_cnt,             32'd6);
      check("f3c_dout", 32'(rif.dout),        32'h3C);
      check("f3c_ferr", 32'(rif.frame_err),   32'h0);

      // parity: 0x07 has three ones, so even parity needs parity bit 1
      send_frame(8'h07, 0, wp, 1'b1);
      check("par1_cnt",  done_cnt,            32'd7);
      check("par1_dout", 32'(rif.dout),       32'h07);
      check("par1_perr", 32'(rif.par_err),    32'h0);
      send_frame(8'h07, 0, wp, 1'b0);
      check("par0_cnt",  done_cnt,            32'd8);
      check("par0_ferr", 32'(rif.frame_err),  32'h0);
`ifdef UART_RX_PARITY_EN
      check("par0_perr", 32'(rif.par_err),    32'h1);
`else
      check("par0_perr", 32'(rif.par_err),    32'h0);
`endif

      check("pulse_width", max_run, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
